// File: rtl/fft_post_reorder_pkg.sv
// Shared constants for the FFT/IFFT output back end: default sizes, read FSM
// state encodings and transform direction codes.
package fft_post_reorder_pkg;

  localparam int DEF_LOG2N      = 10;
  localparam int DEF_REAL_WIDTH = 16;
  localparam int DEF_IMGN_WIDTH = 16;
  localparam int CPLX_WIDTH     = DEF_REAL_WIDTH + DEF_IMGN_WIDTH;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic DIR_FFT  = 1'b0;
  localparam logic DIR_IFFT = 1'b1;

endpackage

// File: rtl/fft_post_scale.sv
// Registered conjugate/shift datapath for one component of a complex sample.
// FFT_POST_ROUND_SAT_EN selects round-half-up shifting with saturation.
module fft_post_scale
  import fft_post_reorder_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FFT_SHIFT  = 0,
  parameter int unsigned IFFT_SHIFT = 10,
  parameter bit          CONJ       = 1'b0
) (
  input  logic             iclk,
  input  logic             rst,
  input  logic             idir,
  input  logic [WIDTH-1:0] idata,
  output logic [WIDTH-1:0] odata
);

  // Two guard bits: one for negating the most negative value, one for rounding.
  localparam int unsigned EW = WIDTH + 2;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] val;
  logic [WIDTH-1:0]     res;
  int unsigned          sh;

`ifdef FFT_POST_ROUND_SAT_EN
  localparam logic signed [EW-1:0] MaxV = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MinV = {3'b111, {(WIDTH-1){1'b0}}};
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] shf;
`endif

  always_comb begin
    ext = {{2{idata[WIDTH-1]}}, idata};
    sh  = (idir == DIR_IFFT) ? IFFT_SHIFT : FFT_SHIFT;
    val = (CONJ && (idir == DIR_IFFT)) ? -ext : ext;
`ifdef FFT_POST_ROUND_SAT_EN
    rnd = (sh != 0) ? val + (EW'(1) << (sh - 1)) : val;
    shf = rnd >>> sh;
    if (shf > MaxV) begin
      res = MaxV[WIDTH-1:0];
    end else if (shf < MinV) begin
      res = MinV[WIDTH-1:0];
    end else begin
      res = shf[WIDTH-1:0];
    end
`else
    res = WIDTH'(val >>> sh);
`endif
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      odata <= '0;
    end else begin
      odata <= res;
    end
  end

endmodule

// File: rtl/fft_post_reorder.sv
// Ping-pong reorder buffer: frames arrive in any address order, leave in natural
// order with per-frame FFT/IFFT scaling. FFT_POST_ROUND_SAT_EN enables rounding.
module fft_post_reorder
  import fft_post_reorder_pkg::*;
#(
  parameter int unsigned LOG2N      = DEF_LOG2N,
  parameter int unsigned REAL_WIDTH = DEF_REAL_WIDTH,
  parameter int unsigned IMGN_WIDTH = DEF_IMGN_WIDTH,
  parameter int unsigned FFT_SHIFT  = 0
) (
  input  logic                  iclk,
  input  logic                  rst,
  input  logic                  ien,
  input  logic [LOG2N-1:0]      iaddr,
  input  logic                  idir,
  input  logic [REAL_WIDTH-1:0] iReal,
  input  logic [IMGN_WIDTH-1:0] iImag,
  output logic                  oen,
  output logic [LOG2N-1:0]      oaddr,
  output logic                  odir,
  output logic [REAL_WIDTH-1:0] oReal,
  output logic [IMGN_WIDTH-1:0] oImag,
  output logic                  oerr
);

  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned CW = REAL_WIDTH + IMGN_WIDTH;

  logic [CW-1:0]    mem [2*N];
  logic [1:0]       dir_q;
  logic [LOG2N-1:0] wcnt_q;
  logic             wbank_q;
  logic             req_q;
  logic             req_bank_q;
  logic [0:0]       state_q;
  logic             rbank_q;
  logic [LOG2N-1:0] rcnt_q;
  logic             rd_vld_q;
  logic             rd_dir_q;
  logic [LOG2N-1:0] rd_addr_q;
  logic [CW-1:0]    rd_data_q;
  logic             frame_done;

  assign frame_done = ien && (wcnt_q == '1);

  // Storage has no reset; only the bookkeeping around it does.
  always_ff @(posedge iclk) begin
    if (ien && !rst) begin
      mem[{wbank_q, iaddr}] <= {iReal, iImag};
    end
    rd_data_q <= mem[{rbank_q, rcnt_q}];
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      dir_q      <= '0;
      wcnt_q     <= '0;
      wbank_q    <= 1'b0;
      req_q      <= 1'b0;
      req_bank_q <= 1'b0;
      state_q    <= IDLE;
      rbank_q    <= 1'b0;
      rcnt_q     <= '0;
      rd_vld_q   <= 1'b0;
      rd_dir_q   <= 1'b0;
      rd_addr_q  <= '0;
      oen        <= 1'b0;
      oaddr      <= '0;
      odir       <= 1'b0;
      oerr       <= 1'b0;
    end else begin
      if (ien) begin
        wcnt_q <= wcnt_q + 1'b1;
        if (wcnt_q == '0) begin
          dir_q[wbank_q] <= idir;
        end
        if (frame_done) begin
          wbank_q <= ~wbank_q;
        end
      end
      req_q      <= frame_done;
      req_bank_q <= wbank_q;

      unique case (state_q)
        IDLE: begin
          if (req_q) begin
            state_q <= DRAIN;
            rbank_q <= req_bank_q;
            rcnt_q  <= '0;
          end
        end
        DRAIN: begin
          if (req_q) begin
            // A request before the last read means the old frame is lost.
            if (rcnt_q != '1) begin
              oerr <= 1'b1;
            end
            rbank_q <= req_bank_q;
            rcnt_q  <= '0;
          end else if (rcnt_q == '1) begin
            state_q <= IDLE;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      rd_vld_q  <= (state_q == DRAIN);
      rd_addr_q <= rcnt_q;
      rd_dir_q  <= dir_q[rbank_q];
      oen       <= rd_vld_q;
      oaddr     <= rd_addr_q;
      odir      <= rd_dir_q;
    end
  end

  fft_post_scale #(
    .WIDTH     (REAL_WIDTH),
    .FFT_SHIFT (FFT_SHIFT),
    .IFFT_SHIFT(LOG2N),
    .CONJ      (1'b0)
  ) u_scale_re (
    .iclk (iclk),
    .rst  (rst),
    .idir (rd_dir_q),
    .idata(rd_data_q[CW-1:IMGN_WIDTH]),
    .odata(oReal)
  );

  fft_post_scale #(
    .WIDTH     (IMGN_WIDTH),
    .FFT_SHIFT (FFT_SHIFT),
    .IFFT_SHIFT(LOG2N),
    .CONJ      (1'b1)
  ) u_scale_im (
    .iclk (iclk),
    .rst  (rst),
    .idir (rd_dir_q),
    .idata(rd_data_q[IMGN_WIDTH-1:0]),
    .odata(oImag)
  );

endmodule

// File: tb/tb_fft_post_reorder.sv
// Bench for fft_post_reorder with N=8: frames are scattered by address, and the
// expected natural-order output is built from the frame contents by the bench.
module tb_fft_post_reorder;

  localparam int LOG2N     = 3;
  localparam int N         = 8;
  localparam int W         = 16;
  localparam int FFT_SHIFT = 0;

  logic          iclk = 1'b0;
  logic          rst;
  logic          ien;
  logic [2:0]    iaddr;
  logic          idir;
  logic [W-1:0]  iReal;
  logic [W-1:0]  iImag;
  logic          oen;
  logic [2:0]    oaddr;
  logic          odir;
  logic [W-1:0]  oReal;
  logic [W-1:0]  oImag;
  logic          oerr;

  always #5 iclk = ~iclk;

  fft_post_reorder #(
    .LOG2N     (LOG2N),
    .REAL_WIDTH(W),
    .IMGN_WIDTH(W),
    .FFT_SHIFT (FFT_SHIFT)
  ) dut (
    .iclk (iclk),
    .rst  (rst),
    .ien  (ien),
    .iaddr(iaddr),
    .idir (idir),
    .iReal(iReal),
    .iImag(iImag),
    .oen  (oen),
    .oaddr(oaddr),
    .odir (odir),
    .oReal(oReal),
    .oImag(oImag),
    .oerr (oerr)
  );

  typedef struct {
    int         ecyc;
    logic [2:0] addr;
    logic       dir;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } item_t;

  item_t obs_q[$];
  item_t exp_q[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int last_edge = 0;
  logic [W-1:0] fre[N];
  logic [W-1:0] fim[N];
  logic [2:0]   fad[N];

  always @(posedge iclk) cyc <= cyc + 1;

  always @(negedge iclk) begin
    if (oen === 1'b1) obs_q.push_back('{cyc, oaddr, odir, oReal, oImag});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arithmetic on plain integers: optional negate, divide by 2^shift.
  function automatic logic [W-1:0] model_scale(input logic [W-1:0] v, input logic ifft,
                                               input bit conj);
    longint a;
    int sh;
    sh = ifft ? LOG2N : FFT_SHIFT;
    a = longint'($signed(v));
    if (ifft && conj) a = -a;
`ifdef FFT_POST_ROUND_SAT_EN
    if (sh > 0) a = a + (longint'(1) << (sh - 1));
    a = a >>> sh;
    if (a > 32767) a = 32767;
    if (a < -32768) a = -32768;
`else
    a = a >>> sh;
`endif
    return a[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] a, input logic d,
                       input logic [W-1:0] r, input logic [W-1:0] m);
    ien = en; iaddr = a; idir = d; iReal = r; iImag = m;
    @(negedge iclk);
  endtask

  task automatic shuffle();
    logic [2:0] tmp;
    for (int k = 0; k < N; k++) fad[k] = 3'(k);
    for (int k = N - 1; k > 0; k--) begin
      int j;
      j = int'($urandom_range(k));
      tmp = fad[k]; fad[k] = fad[j]; fad[j] = tmp;
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) begin
      fre[k] = W'($urandom);
      fim[k] = W'($urandom);
    end
  endtask

  // stall_k >= 0 freezes the read counter for a few cycles to provoke an overrun.
  task automatic send_frame(input logic d, input bit gaps, input int stall_k);
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        repeat ($urandom_range(2)) drive(1'b0, 3'($urandom), 1'($urandom), W'($urandom),
                                         W'($urandom));
      end
      if (k == stall_k) force dut.rcnt_q = 3'd0;
      if (k == stall_k + 3) release dut.rcnt_q;
      drive(1'b1, fad[k], (k == 0) ? d : 1'($urandom), fre[k], fim[k]);
    end
    ien = 1'b0;
    last_edge = cyc;
    for (int a = 0; a < N; a++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(fad[k]) == a) begin
          exp_q.push_back('{last_edge + 3 + a, 3'(a), d, model_scale(fre[k], d, 1'b0),
                            model_scale(fim[k], d, 1'b1)});
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag, input int min_ecyc);
    int t;
    int n;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 100) begin
      @(negedge iclk);
      t++;
    end
    repeat (4) @(negedge iclk);
    while (obs_q.size() > 0 && obs_q[0].ecyc < min_ecyc) void'(obs_q.pop_front());
    chk($sformatf("%s.count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].cycle", tag, i), 32'(obs_q[i].ecyc), 32'(exp_q[i].ecyc));
      chk($sformatf("%s[%0d].oaddr", tag, i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
      chk($sformatf("%s[%0d].odir", tag, i), 32'(obs_q[i].dir), 32'(exp_q[i].dir));
      chk($sformatf("%s[%0d].oReal", tag, i), 32'(obs_q[i].re), 32'(exp_q[i].re));
      chk($sformatf("%s[%0d].oImag", tag, i), 32'(obs_q[i].im), 32'(exp_q[i].im));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; ien = 1'b0; iaddr = '0; idir = 1'b0; iReal = '0; iImag = '0;
    repeat (3) @(negedge iclk);
    chk("reset.oen", 32'(oen), 32'd0);
    chk("reset.oaddr", 32'(oaddr), 32'd0);
    chk("reset.odir", 32'(odir), 32'd0);
    chk("reset.oReal", 32'(oReal), 32'd0);
    chk("reset.oImag", 32'(oImag), 32'd0);
    chk("reset.oerr", 32'(oerr), 32'd0);
    rst = 1'b0;
    @(negedge iclk);
    obs_q.delete();

    // Bit-reversed IFFT frame: re = 8*idx, im = -8*idx.
    begin
      logic [2:0] br [N];
      br = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
      for (int k = 0; k < N; k++) begin
        fad[k] = br[k];
        fre[k] = W'(8 * int'(br[k]));
        fim[k] = W'(-8 * int'(br[k]));
      end
    end
    send_frame(1'b1, 1'b0, -1);
    check_outputs("bitrev_ifft", 0);

    // Two gapless FFT frames.
    shuffle(); rand_data(); send_frame(1'b0, 1'b0, -1);
    shuffle(); rand_data(); send_frame(1'b0, 1'b0, -1);
    check_outputs("b2b_fft", 0);
    chk("b2b_fft.oerr", 32'(oerr), 32'd0);

    // Direction switching between adjacent frames.
    shuffle(); rand_data(); send_frame(1'b1, 1'b0, -1);
    shuffle(); rand_data(); send_frame(1'b0, 1'b0, -1);
    check_outputs("alt_dir", 0);

    // Rounding and extreme values, IFFT then FFT.
    shuffle();
    begin
      int rv [N];
      int iv [N];
      rv = '{12, -12, 4, -4, 32767, -32768, 20, 7};
      iv = '{-32768, 32767, 12, -12, 0, -1, 1, 8};
      for (int k = 0; k < N; k++) begin
        fre[k] = W'(rv[k]);
        fim[k] = W'(iv[k]);
      end
      send_frame(1'b1, 1'b0, -1);
      send_frame(1'b0, 1'b0, -1);
    end
    check_outputs("edge_vals", 0);

    // Random frames with random gaps and directions.
    for (int f = 0; f < 6; f++) begin
      shuffle(); rand_data();
      send_frame(1'($urandom), 1'b1, -1);
    end
    check_outputs("random", 0);
    chk("random.oerr", 32'(oerr), 32'd0);

    // Overrun: stall the drain of frame A while frame B arrives.
    shuffle(); rand_data(); send_frame(1'b0, 1'b0, -1);
    exp_q.delete();
    shuffle(); rand_data(); send_frame(1'b1, 1'b0, 3);
    repeat (N + 6) @(negedge iclk);
    chk("overrun.oerr", 32'(oerr), 32'd1);
    check_outputs("overrun", last_edge + 3);
    repeat (20) @(negedge iclk);
    chk("overrun.oerr_sticky", 32'(oerr), 32'd1);
    rst = 1'b1;
    @(negedge iclk);
    rst = 1'b0;
    chk("overrun.oerr_cleared", 32'(oerr), 32'd0);
    obs_q.delete();

    // Reset in the middle of a frame drops the partial frame.
    for (int k = 0; k < 5; k++) drive(1'b1, 3'(k), 1'b1, W'($urandom), W'($urandom));
    ien = 1'b0;
    rst = 1'b1;
    @(negedge iclk);
    rst = 1'b0;
    @(negedge iclk);
    shuffle(); rand_data(); send_frame(1'b0, 1'b0, -1);
    check_outputs("mid_reset", 0);
    chk("final.oerr", 32'(oerr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
